// File: rtl/pixel_writer_if.sv
// -----------------------------------------------------------------------------
// pixel_writer_if
// Bundles the pixel capture strobe, the framebuffer write port and the frame
// status signals of pixel_writer.
//
//   pixel_valid/pixel_x/pixel_y/red_in/green_in/blue_in : pixel from the marcher
//   fb_ready                                             : framebuffer accepts write
//   fb_we/fb_addr/fb_data                                : framebuffer write request
//   frame_done/frame_count/overflow                      : frame status
//   wr_state                                             : write FSM state (0 IDLE, 1 WRITE)
//
// Handshake: fb_we is a valid. A write transfers on every rising clock edge
// where fb_we && fb_ready. While fb_we is high and fb_ready is low,
// fb_addr/fb_data/fb_we hold their values. fb_we never drops without a
// transfer except on reset.
//
// Modports: slave = pixel_writer, master = the environment around it.
// -----------------------------------------------------------------------------
interface pixel_writer_if #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH * HEIGHT);

    logic          pixel_valid;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic [7:0]    red_in;
    logic [7:0]    green_in;
    logic [7:0]    blue_in;
    logic          fb_ready;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [15:0]   fb_data;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          overflow;
    logic          wr_state;

    modport slave (
        input  pixel_valid, pixel_x, pixel_y, red_in, green_in, blue_in, fb_ready,
        output fb_we, fb_addr, fb_data, frame_done, frame_count, overflow, wr_state
    );

    modport master (
        output pixel_valid, pixel_x, pixel_y, red_in, green_in, blue_in, fb_ready,
        input  fb_we, fb_addr, fb_data, frame_done, frame_count, overflow, wr_state
    );
endinterface

// File: rtl/pixel_writer.sv
// -----------------------------------------------------------------------------
// pixel_writer
// Captures finished pixels from the raymarcher, packs RGB888 to RGB565,
// buffers them in a small FIFO and writes them to the framebuffer at
// address y*WIDTH+x. Flags the last pixel of each frame.
//
// Ports:
//   clk_in : system clock
//   rst_in : asynchronous active-high reset
//   bus    : pixel_writer_if.slave (pixel input, framebuffer port, status)
//
// Latency: a pixel strobed at clock edge N is registered at N (address
// multiply + colour pack). It is pushed into the FIFO at N+1. The write FSM
// can load it at N+2, so fb_we rises after edge N+2 at the earliest.
// -----------------------------------------------------------------------------
module pixel_writer #(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int FIFO_DEPTH = 8,
    parameter int SKIP_FIRST = 1
) (
    input logic           clk_in,
    input logic           rst_in,
    pixel_writer_if.slave bus
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH * HEIGHT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + AW + 16;

    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    // ---------------- capture stage ----------------
    logic          skip_q;
    logic          cap_valid_q;
    logic [AW-1:0] cap_addr_q;
    logic [15:0]   cap_data_q;
    logic          cap_last_q;
    logic          in_range;

    assign in_range = (bus.pixel_x <= X_LAST) && (bus.pixel_y <= Y_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            skip_q      <= (SKIP_FIRST != 0);
            cap_valid_q <= 1'b0;
            cap_addr_q  <= '0;
            cap_data_q  <= '0;
            cap_last_q  <= 1'b0;
        end else begin
            cap_valid_q <= 1'b0;
            if (bus.pixel_valid) begin
                // The marcher sits in PIXEL_DONE with a stale colour out of
                // reset, so its first strobe only disarms the skip flag.
                if (skip_q) begin
                    skip_q <= 1'b0;
                end else if (in_range) begin
                    cap_valid_q <= 1'b1;
                    cap_addr_q  <= AW'(bus.pixel_y) * WIDTH_A + AW'(bus.pixel_x);
                    cap_data_q  <= {bus.red_in[7:3], bus.green_in[7:2], bus.blue_in[7:3]};
                    cap_last_q  <= (bus.pixel_x == X_LAST) && (bus.pixel_y == Y_LAST);
                end
            end
        end
    end

    // ---------------- FIFO of {last, addr, data} ----------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          full, push, pop;
    logic [EW-1:0] head, next_head;

    state_t        state_q;
    logic          fb_we_q;
    logic [AW-1:0] fb_addr_q;
    logic [15:0]   fb_data_q;
    logic          last_q;
    logic          frame_done_q;
    logic [15:0]   frame_count_q;

    assign full = (count_q == DEPTH_C);
    assign pop  = fb_we_q && bus.fb_ready;
    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    assign push = cap_valid_q && (!full || pop);

    assign head      = mem[rd_ptr_q];
    assign next_head = mem[rd_ptr_q + PW'(1)];

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr_q] <= {cap_last_q, cap_addr_q, cap_data_q};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (cap_valid_q && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ---------------- write FSM ----------------
    // The output registers always mirror the FIFO head while in WRITE; the
    // entry stays in the FIFO until the framebuffer accepts it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= S_IDLE;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            last_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        {last_q, fb_addr_q, fb_data_q} <= head;
                        fb_we_q <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (bus.fb_ready) begin
                        if (last_q) begin
                            frame_done_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 16'd1;
                        end
                        // count_q > 1 means a second entry is already stored
                        // behind the head being popped now.
                        if (count_q > CW'(1)) begin
                            {last_q, fb_addr_q, fb_data_q} <= next_head;
                        end else begin
                            fb_we_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    fb_we_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fb_we       = fb_we_q;
    assign bus.fb_addr     = fb_addr_q;
    assign bus.fb_data     = fb_data_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_count = frame_count_q;
    assign bus.overflow    = overflow_q;
    assign bus.wr_state    = state_q;
endmodule

// File: tb/tb_pixel_writer.sv
// -----------------------------------------------------------------------------
// tb_pixel_writer
// Directed bench for pixel_writer: skip of the first strobe, stalled write,
// FIFO overflow, frame completion, out-of-range drop and asynchronous reset
// during a write. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pixel_writer;
    localparam int WIDTH      = 1280;
    localparam int HEIGHT     = 720;
    localparam int FIFO_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_writer_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus ();

    pixel_writer #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(FIFO_DEPTH), .SKIP_FIRST(1)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    // Scoreboard: expected writes as {addr[19:0], data[15:0]} in order.
    logic [35:0] exp_q[$];
    logic [35:0] exp_e;
    int n_assert = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int n_fd     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack565(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
        bus.pixel_valid = 1'b1;
        bus.pixel_x     = 11'(x);
        bus.pixel_y     = 10'(y);
        bus.red_in      = r;
        bus.green_in    = g;
        bus.blue_in     = b;
        step();
    endtask

    task automatic idle(input int n);
        bus.pixel_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic expect_px(input int x, input int y, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b);
        exp_q.push_back({20'(y * WIDTH + x), pack565(r, g, b)});
    endtask

    // Wait (bounded) until every expected write has been seen and fb_we is low.
    task automatic drain(input string tag);
        for (int k = 0; k < 100 && (exp_q.size() != 0 || bus.fb_we); k++) step();
        chk(tag, {62'd0, exp_q.size() != 0, bus.fb_we}, 64'd0);
    endtask

    // Write monitor: a write transfers at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.fb_we && bus.fb_ready) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL unexpected_write: observed addr %0h data %0h, expected no write",
                       bus.fb_addr, bus.fb_data);
            end else begin
                exp_e = exp_q.pop_front();
                chk("write_addr_data", {28'd0, bus.fb_addr, bus.fb_data}, {28'd0, exp_e});
            end
        end
        if (!rst && bus.frame_done) n_fd++;
    end

    initial begin
        bus.pixel_valid = 1'b0;
        bus.pixel_x     = '0;
        bus.pixel_y     = '0;
        bus.red_in      = '0;
        bus.green_in    = '0;
        bus.blue_in     = '0;
        bus.fb_ready    = 1'b0;

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) step();
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_fb_addr_data", {bus.fb_addr, bus.fb_data}, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_frame_count", bus.frame_count, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_wr_state", bus.wr_state, 0);
        rst = 1'b0;
        step();

        // ---- 1: first strobe skipped, second written ----
        bus.fb_ready = 1'b1;
        pix(5, 3, 8'hFF, 8'h80, 8'h10);
        exp_q.push_back({20'd3846, 16'h07FF});
        pix(6, 3, 8'h00, 8'hFC, 8'hF8);
        idle(1);
        drain("t1_drain");
        chk("t1_writes", n_writes, 1);

        // ---- 2: write held stable while fb_ready is low ----
        bus.fb_ready = 1'b0;
        exp_q.push_back({20'd0, 16'hF800});
        pix(0, 0, 8'hF8, 8'h00, 8'h00);
        idle(0);
        for (int k = 0; k < 20 && !bus.fb_we; k++) step();
        repeat (10) begin
            @(negedge clk);
            chk("t2_hold", {bus.fb_we, bus.fb_addr, bus.fb_data}, {1'b1, 20'd0, 16'hF800});
        end
        @(posedge clk);
        #1;
        bus.fb_ready = 1'b1;
        drain("t2_drain");
        chk("t2_writes", n_writes, 2);

        // ---- 5: out-of-range pixels dropped silently ----
        pix(1280, 0, 8'h11, 8'h22, 8'h33);
        pix(0, 720, 8'h11, 8'h22, 8'h33);
        idle(10);
        chk("t5_writes", n_writes, 2);
        chk("t5_overflow", bus.overflow, 0);
        chk("t5_fb_we", bus.fb_we, 0);

        // ---- 4: last pixel of the frame ----
        chk("t4_fd_before", n_fd, 0);
        exp_q.push_back({20'd921599, 16'h11AA});
        pix(1279, 719, 8'h12, 8'h34, 8'h56);
        idle(1);
        drain("t4_drain");
        idle(3);
        chk("t4_frame_done_pulses", n_fd, 1);
        chk("t4_frame_count", bus.frame_count, 1);
        chk("t4_writes", n_writes, 3);

        // ---- 3: nine strobes into an 8-deep FIFO with fb_ready low ----
        bus.fb_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < FIFO_DEPTH)
                expect_px(i, 10, 8'(i * 32), 8'(i * 16 + 4), 8'(255 - i * 8));
            pix(i, 10, 8'(i * 32), 8'(i * 16 + 4), 8'(255 - i * 8));
        end
        idle(4);
        chk("t3_overflow_set", bus.overflow, 1);
        chk("t3_fb_we_pending", bus.fb_we, 1);
        bus.fb_ready = 1'b1;
        drain("t3_drain");
        chk("t3_writes", n_writes, 11);
        chk("t3_overflow_sticky", bus.overflow, 1);
        chk("t3_frame_count", bus.frame_count, 1);

        // ---- 6: reset during a write with entries queued ----
        bus.fb_ready = 1'b0;
        pix(1, 20, 8'hA0, 8'hA0, 8'hA0);
        pix(2, 20, 8'hB0, 8'hB0, 8'hB0);
        pix(3, 20, 8'hC0, 8'hC0, 8'hC0);
        idle(6);
        chk("t6_fb_we_before", bus.fb_we, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_fb_we_async", bus.fb_we, 0);
        chk("t6_overflow_cleared", bus.overflow, 0);
        chk("t6_frame_count_cleared", bus.frame_count, 0);
        exp_q.delete();
        repeat (2) step();
        rst = 1'b0;
        bus.fb_ready = 1'b1;
        idle(20);
        chk("t6_no_writes", n_writes, 11);
        chk("t6_fb_we_idle", bus.fb_we, 0);
        // Skip flag re-armed by reset: first strobe dropped, second written.
        pix(7, 7, 8'h01, 8'h02, 8'h03);
        expect_px(8, 7, 8'hAA, 8'hBB, 8'hCC);
        pix(8, 7, 8'hAA, 8'hBB, 8'hCC);
        idle(1);
        drain("t6_post_drain");
        chk("t6_post_writes", n_writes, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
